// File: rtl/trdb_reg_bank_pkg.sv
// Shared types, register offsets and CTRL field positions for the trace
// encoder register bank.
package trdb_pkg;

  typedef enum logic [1:0] {
    DELTA_ADDRESS = 2'd0,
    FULL_ADDRESS  = 2'd1
  } ioptions_e;

  typedef enum logic {
    CH_OFF = 1'b0,
    CH_ON  = 1'b1
  } ch_state_e;

  localparam int unsigned TRDB_OFF_CTRL    = 'h00;
  localparam int unsigned TRDB_OFF_ENABLE  = 'h04;
  localparam int unsigned TRDB_OFF_STATUS  = 'h08;
  localparam int unsigned TRDB_OFF_ID      = 'h0C;
  localparam int unsigned TRDB_OFF_STOPCNT = 'h10;

  localparam logic [31:0] TRDB_REG_ID = 32'h7DB0_0001;

  localparam int unsigned CTRL_ACTIVATED_BIT  = 0;
  localparam int unsigned CTRL_NOCONTEXT_BIT  = 1;
  localparam int unsigned CTRL_NOTIME_BIT     = 2;
  localparam int unsigned CTRL_DELTA_ADDR_BIT = 3;
  localparam int unsigned CTRL_CFG_LSB        = 4;
  localparam int unsigned CTRL_CFG_MSB        = 5;
  localparam int unsigned STATUS_ACT_BIT      = 31;

  function automatic logic is_valid_ioption(input logic [1:0] v);
    return (v == 2'(DELTA_ADDRESS)) || (v == 2'(FULL_ADDRESS));
  endfunction

endpackage

// File: rtl/trdb_reg_bank_if.sv
// APB slave bundle for the trace register bank; names follow the slave view.
interface trdb_reg_bank_if #(
  parameter int ADDR_W = 8
);
  logic              psel_i;
  logic              penable_i;
  logic              pwrite_i;
  logic [ADDR_W-1:0] paddr_i;
  logic [31:0]       pwdata_i;
  logic [31:0]       prdata_o;
  logic              pready_o;
  logic              pslverr_o;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/pulp_clock_gating.sv
// Latch-based clock gate: enable is captured while the clock is low so the
// gated clock never glitches.
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);
  logic r_en_latch;

  always_latch begin
    if (!clk_i) r_en_latch <= en_i | test_en_i;
  end

  assign clk_o = clk_i & r_en_latch;
endmodule

// File: rtl/trdb_reg_bank_ch.sv
// One traced channel: enable FSM with hw-on > hw-off > sw priority and a
// saturating stop counter.
//   state  | meaning
//   CH_OFF | channel trace disabled
//   CH_ON  | channel trace enabled
module trdb_reg_ch
  import trdb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_active,
  input  logic             i_req_on,
  input  logic             i_req_off,
  input  logic             i_sw_wr,
  input  logic             i_sw_val,
  input  logic             i_cnt_clr,
  output logic             o_enable,
  output logic [CNT_W-1:0] o_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_on;
  logic             w_off;

  // An off request only counts when no on request competes with it.
  assign w_on  = i_active & i_req_on;
  assign w_off = i_active & i_req_off & ~i_req_on;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= CH_OFF;
      r_cnt   <= '0;
    end else begin
      if (r_state == CH_OFF) begin
        if (w_on || (!w_off && i_sw_wr && i_sw_val)) r_state <= CH_ON;
      end else begin
        if (!w_on && (w_off || (i_sw_wr && !i_sw_val))) r_state <= CH_OFF;
      end
      if (i_cnt_clr) r_cnt <= '0;
      else if (r_state == CH_ON && w_off && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_enable = (r_state == CH_ON);
  assign o_cnt    = r_cnt;
endmodule

// File: rtl/trdb_reg_bank.sv
// Trace encoder control/status register bank: APB decode, CTRL fields,
// per-channel enable/stop-count instances and the encoder clock gate.
module trdb_reg_bank
  import trdb_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  trdb_reg_bank_if.slave    apb,
  input  logic [NUM_CH-1:0] trace_req_on_i,
  input  logic [NUM_CH-1:0] trace_req_off_i,
  output logic [NUM_CH-1:0] trace_enable_o,
  output logic              trace_activated_o,
  output logic              nocontext_o,
  output logic              notime_o,
  output logic              delta_address_o,
  output logic              encoder_mode_o,
  output ioptions_e         configuration_o,
  output logic              clk_gated_o
);
  logic              r_activated;
  logic              r_nocontext;
  logic              r_notime;
  logic              r_delta_address;
  ioptions_e         r_configuration;

  logic              w_access, w_wr, w_mapped, w_cfg_ok;
  logic              w_sel_ctrl, w_sel_enable, w_sel_status, w_sel_id;
  logic [NUM_CH-1:0] w_sel_cnt;
  logic [NUM_CH-1:0] w_enable;
  logic [CNT_W-1:0]  w_cnt [NUM_CH];
  logic [31:0]       w_rdata;
  logic              w_unused_pwdata;

  assign w_access     = apb.psel_i & apb.penable_i;
  assign w_wr         = w_access & apb.pwrite_i;
  assign w_sel_ctrl   = (apb.paddr_i == ADDR_W'(TRDB_OFF_CTRL));
  assign w_sel_enable = (apb.paddr_i == ADDR_W'(TRDB_OFF_ENABLE));
  assign w_sel_status = (apb.paddr_i == ADDR_W'(TRDB_OFF_STATUS));
  assign w_sel_id     = (apb.paddr_i == ADDR_W'(TRDB_OFF_ID));
  assign w_mapped     = w_sel_ctrl | w_sel_enable | w_sel_status | w_sel_id | (|w_sel_cnt);
  assign w_cfg_ok     = is_valid_ioption(apb.pwdata_i[CTRL_CFG_MSB:CTRL_CFG_LSB]);
  assign w_unused_pwdata = ^apb.pwdata_i[31:6];

  // A bad configuration still lets the other CTRL bits land, but flags the access.
  assign apb.pslverr_o = w_access & (~w_mapped |
                         (apb.pwrite_i & (w_sel_status | w_sel_id | (w_sel_ctrl & ~w_cfg_ok))));
  assign apb.pready_o  = 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_activated     <= 1'b0;
      r_nocontext     <= 1'b1;
      r_notime        <= 1'b1;
      r_delta_address <= 1'b1;
      r_configuration <= DELTA_ADDRESS;
    end else if (w_wr && w_sel_ctrl) begin
      r_activated     <= apb.pwdata_i[CTRL_ACTIVATED_BIT];
      r_nocontext     <= apb.pwdata_i[CTRL_NOCONTEXT_BIT];
      r_notime        <= apb.pwdata_i[CTRL_NOTIME_BIT];
      r_delta_address <= apb.pwdata_i[CTRL_DELTA_ADDR_BIT];
      if (w_cfg_ok) r_configuration <= ioptions_e'(apb.pwdata_i[CTRL_CFG_MSB:CTRL_CFG_LSB]);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_sel_cnt[k] = (apb.paddr_i == ADDR_W'(TRDB_OFF_STOPCNT + 4 * k));

    trdb_reg_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_active  (r_activated),
      .i_req_on  (trace_req_on_i[k]),
      .i_req_off (trace_req_off_i[k]),
      .i_sw_wr   (w_wr & w_sel_enable),
      .i_sw_val  (apb.pwdata_i[k]),
      .i_cnt_clr (w_wr & w_sel_cnt[k]),
      .o_enable  (w_enable[k]),
      .o_cnt     (w_cnt[k])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (w_access) begin
      if (w_sel_ctrl) begin
        w_rdata = {26'd0, r_configuration, r_delta_address, r_notime, r_nocontext, r_activated};
      end else if (w_sel_enable) begin
        w_rdata = 32'(w_enable);
      end else if (w_sel_status) begin
        w_rdata = 32'(w_enable);
        w_rdata[STATUS_ACT_BIT] = r_activated;
      end else if (w_sel_id) begin
        w_rdata = TRDB_REG_ID;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_sel_cnt[k]) w_rdata = 32'(w_cnt[k]);
      end
    end
  end

  assign apb.prdata_o = w_rdata;

  assign trace_enable_o    = w_enable;
  assign trace_activated_o = r_activated;
  assign nocontext_o       = r_nocontext;
  assign notime_o          = r_notime;
  assign delta_address_o   = r_delta_address;
  assign encoder_mode_o    = 1'b0;
  assign configuration_o   = r_configuration;

  // Gate is held off while reset is asserted, independent of CTRL contents.
  pulp_clock_gating u_cg (
    .clk_i     (clk_i),
    .en_i      (r_activated & ~rst_i),
    .test_en_i (1'b0),
    .clk_o     (clk_gated_o)
  );
endmodule
